vout_timing_meas: RTL
=====================

Name: vout_timing_meas

Overview:
- Measures the final post-processed video stream in the VCLK_Tx domain, i.e. the sync nibble and valid strobe leaving the colour-conversion stage, alongside the output register stage.
- Reports debounced output timing to the NIOS II status path: total samples per line, active samples per line, lines per frame and active lines per frame.
- Flags loss or change of timing so the OSD and the filter auto-selection can react.

Parameters:
- HCNT_W, 12, width of the horizontal sample counters.
- VCNT_W, 11, width of the line counters.
- STABLE_FRAMES, 3, number of consecutive identical frame records required before publishing; legal range 1..15.

Ports:
- VCLK_Tx  in  1  output pixel clock.
- nVRST_Tx  in  1  asynchronous active-low reset.
- vdata_valid_i  in  1  sample strobe; the block counts and samples sync only when this is 1.
- Sync_i  in  4  sync nibble: {nVSYNC, nBLANK, nHSYNC, nCSYNC}.
- h_total_o  out  HCNT_W  valid samples per line.
- h_active_o  out  HCNT_W  samples with nBLANK=1 per line.
- v_total_o  out  VCNT_W  lines per frame.
- v_active_o  out  VCNT_W  lines per frame with h_active>0.
- timing_valid_o  out  1  published values are locked.
- timing_changed_o  out  1  single-cycle pulse when the published record changes.
- interlaced_o  out  1  see Optional Feature.

Behaviour:
- Reset: every output, counter and state register is 0; FSM is in SEARCH.
- Sampling:
  - prev_sync updates only on vdata_valid_i=1.
  - hs_fall = prev nHSYNC=1 and cur nHSYNC=0.
  - vs_fall = same rule applied to nVSYNC.
  - All edge detection and counting is gated by vdata_valid_i, so results are in samples, not clocks.
- hcnt:
  - Set to 1 on hs_fall, else increments.
  - Saturates at all-ones; saturation raises line_err.
- hact:
  - Counts samples with nBLANK=1.
  - Captured into line_hact and cleared on hs_fall.
  - At the same hs_fall, line_htot <= hcnt.
- vcnt:
  - Increments on hs_fall.
  - vact increments on an hs_fall whose captured hact is nonzero.
  - Saturation of vcnt at all-ones raises line_err.
- Frame close on vs_fall:
  - Record = {last line_htot, last line_hact, vcnt, vact}.
  - vcnt and vact restart at 0. If hs_fall coincides with vs_fall, they restart at 1 and 1 respectively (vact only if hact>0), with the line capture done first.
- FSM:
  - SEARCH: ignores data until the first vs_fall, then goes to MEASURE with stable_cnt=0. The first partial frame is never recorded.
  - MEASURE: on each vs_fall, compares the record with the previous record.
    - Equal: stable_cnt++.
    - Not equal: stable_cnt=0.
    - When stable_cnt reaches STABLE_FRAMES-1 and the record is equal: publish, go to LOCKED.
    - With STABLE_FRAMES=1, the second full frame publishes.
  - LOCKED: on each vs_fall, if the record differs from the previous record: timing_valid_o <= 0, stable_cnt=0, go to MEASURE. Published values hold their last contents.
  - Any state: line_err returns the FSM to SEARCH, clears timing_valid_o, clears line_err and clears the counters.
- Publish:
  - h_total_o, h_active_o, v_total_o and v_active_o update, and timing_valid_o rises, one clock after the completing vs_fall sample.
  - timing_changed_o pulses in that same cycle only if the new record differs from the previously published one. No pulse on the first lock after reset.
- vdata_valid_i=0 for any duration: no state change; timeouts are measured in valid samples only.
- Reset mid-frame: immediate clear to reset values. The first vs_fall after reset is treated as in SEARCH.

Optional Feature:
- Macro: VOUT_TMEAS_INTERLACE_EN.
- With the macro defined:
  - At each vs_fall, the block latches hcnt (the vsync phase within the line).
  - Two consecutive frames whose phases differ by more than line_htot/4, with v_total differing by exactly 1, set field_alt.
  - The interlace status is part of the record: interlaced_o publishes as field_alt.
  - Frame comparison uses max(v_total) across the two fields, so alternating 262/263 counts as stable.
- Without the macro: interlaced_o is tied to 0, there is no phase logic, and records compare exactly.

Test Plan:
1. Continuous valid; frames of 20 lines × 100 samples; nHSYNC low 8 samples; nBLANK high 80 samples on lines 3–17; nVSYNC fall at line start. Response: after 4 vs_falls, timing_valid_o=1 with h_total=100, h_active=80, v_total=20, v_active=15; no timing_changed pulse.
2. From locked test 1, change line length to 104 starting frame 6. Response: timing_valid_o=0 one clock after frame-6 closing vs_fall; relock after 3 equal frames with h_total=104; timing_changed_o is high exactly one cycle.
3. Test 1 stream with vdata_valid_i toggling 1/0 every clock. Response: identical published values to test 1; lock time doubles in clocks.
4. Locked, then nHSYNC held high for 4096 valid samples. Response: hcnt saturates, FSM goes to SEARCH, timing_valid_o=0; normal stream relocks after 1+3 frames.
5. nVRST_Tx asserted mid-line while locked. Response: all outputs 0 same cycle; after release, relock only after first vs_fall plus STABLE_FRAMES matching frames.
6. With VOUT_TMEAS_INTERLACE_EN: alternate 20/21-line fields, vsync mid-line on odd fields. Response: interlaced_o=1, v_total_o=21, timing_valid_o stays 1; without the macro, interlaced_o=0 and lock never asserts.

Source files
------------

// File: rtl/vout_timing_meas.sv
// -----------------------------------------------------------------------------
// vout_timing_meas
//   Measures the post-processed output video timing in the VCLK_Tx domain and
//   reports debounced line/frame geometry to the NIOS II status path.
//   All edge detection and counting is gated by vdata_valid_i, so every count
//   is in valid samples, not clocks.
//
//   Ports
//     VCLK_Tx          output pixel clock
//     nVRST_Tx         asynchronous active-low reset
//     vdata_valid_i    sample strobe
//     Sync_i[3:0]      {nVSYNC, nBLANK, nHSYNC, nCSYNC}
//     h_total_o        valid samples per line
//     h_active_o       nBLANK=1 samples per active line
//     v_total_o        lines per frame
//     v_active_o       lines per frame with nonzero active width
//     timing_valid_o   published record is locked
//     timing_changed_o one-cycle pulse when a (re)lock publishes a new record
//     interlaced_o     alternating-field detection (0 unless the option is built)
//
//   Build option
//     VOUT_TMEAS_INTERLACE_EN : track the vsync phase within the line and treat
//     alternating N/N+1 line fields with shifted vsync as one stable timing.
// -----------------------------------------------------------------------------
module vout_timing_meas #(
  parameter int HCNT_W        = 12,
  parameter int VCNT_W        = 11,
  parameter int STABLE_FRAMES = 3    // legal range 1..15 (stable_cnt is 4 bits)
) (
  input  logic              VCLK_Tx,
  input  logic              nVRST_Tx,
  input  logic              vdata_valid_i,
  input  logic [3:0]        Sync_i,
  output logic [HCNT_W-1:0] h_total_o,
  output logic [HCNT_W-1:0] h_active_o,
  output logic [VCNT_W-1:0] v_total_o,
  output logic [VCNT_W-1:0] v_active_o,
  output logic              timing_valid_o,
  output logic              timing_changed_o,
  output logic              interlaced_o
);

  localparam logic [HCNT_W-1:0] HMAX = '1;
  localparam logic [VCNT_W-1:0] VMAX = '1;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  typedef struct packed {
    logic [HCNT_W-1:0] htot;
    logic [HCNT_W-1:0] hact;
    logic [VCNT_W-1:0] vtot;
    logic [VCNT_W-1:0] vact;
    logic              ilace;
  } rec_t;

  state_e            state_q;
  logic              prev_hs_q, prev_vs_q;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [HCNT_W-1:0] hact_q, hact_d;
  logic [HCNT_W-1:0] line_htot_q, line_htot_d;
  logic [HCNT_W-1:0] act_w_q, act_w_d;
  logic [VCNT_W-1:0] vcnt_q, vcnt_d;
  logic [VCNT_W-1:0] vact_q, vact_d;
  logic [3:0]        stable_cnt_q;
  rec_t              prev_rec_q;
  logic              prev_vld_q;
  logic              pub_seen_q;

  rec_t              rec;
  logic [HCNT_W-1:0] rec_htot;
  logic              smp, hs_fall, vs_fall, nblank, cap_act;
  logic              line_err, rec_eq, stable_hit, pub_diff;
  logic              unused_csync;

  assign smp          = vdata_valid_i;
  assign nblank       = Sync_i[2];
  assign unused_csync = Sync_i[0];   // composite sync carries nothing we measure
  assign hs_fall      = smp & prev_hs_q & ~Sync_i[1];
  assign vs_fall      = smp & prev_vs_q & ~Sync_i[3];
  // hact_q is the active count of the line that an hs_fall closes
  assign cap_act      = (hact_q != '0);

  // Saturation of either counter means the stream has no usable sync. The
  // error is consumed in the same cycle it is detected: the FSM drops back to
  // SEARCH and the counters clear, so no sticky error flag is needed.
  assign line_err = (smp & ~hs_fall & (hcnt_q == HMAX)) |
                    (hs_fall & ~vs_fall & (vcnt_q == VMAX));

  // ---------------------------------------------------------------------------
  // Line / frame counters
  // ---------------------------------------------------------------------------
  always_comb begin
    hcnt_d      = hcnt_q;
    hact_d      = hact_q;
    line_htot_d = line_htot_q;
    act_w_d     = act_w_q;
    vcnt_d      = vcnt_q;
    vact_d      = vact_q;
    if (smp) begin
      if (hs_fall) begin
        // the hs_fall sample is the first sample of the new line
        hcnt_d      = HCNT_W'(1);
        hact_d      = HCNT_W'(nblank);
        line_htot_d = hcnt_q;
        if (cap_act) act_w_d = hact_q;
        vcnt_d      = vcnt_q + VCNT_W'(1);
        if (cap_act) vact_d = vact_q + VCNT_W'(1);
      end else begin
        if (hcnt_q != HMAX) hcnt_d = hcnt_q + HCNT_W'(1);
        if (nblank && (hact_q != HMAX)) hact_d = hact_q + HCNT_W'(1);
      end
      if (vs_fall) begin
        // a coinciding hs_fall has already been captured above; that line
        // start belongs to the new frame
        vcnt_d  = hs_fall ? VCNT_W'(1) : '0;
        vact_d  = (hs_fall && cap_act) ? VCNT_W'(1) : '0;
        act_w_d = (hs_fall && cap_act) ? hact_q : '0;
      end
    end
  end

  // Horizontal part of the record reflects the line capture of this sample.
  // h_active is the width of the most recent active line, so trailing blanked
  // lines do not zero it.
  assign rec_htot = hs_fall ? hcnt_q : line_htot_q;

`ifdef VOUT_TMEAS_INTERLACE_EN
  logic [HCNT_W-1:0] phase_q, phase_now, phase_diff;
  logic [VCNT_W-1:0] fld_vtot_q, fld_vact_q;
  logic              fld_vld_q, vtot_adj, field_alt;

  // vsync phase within the line; a vsync on a line start is phase 0
  assign phase_now  = hs_fall ? '0 : hcnt_q;
  assign phase_diff = (phase_now > phase_q) ? (phase_now - phase_q)
                                            : (phase_q - phase_now);
  assign vtot_adj   = (vcnt_q == fld_vtot_q + VCNT_W'(1)) ||
                      (fld_vtot_q == vcnt_q + VCNT_W'(1));
  assign field_alt  = fld_vld_q && vtot_adj && (phase_diff > (rec_htot >> 2));

  always_ff @(posedge VCLK_Tx or negedge nVRST_Tx) begin
    if (!nVRST_Tx) begin
      phase_q    <= '0;
      fld_vtot_q <= '0;
      fld_vact_q <= '0;
      fld_vld_q  <= 1'b0;
    end else if (line_err) begin
      fld_vld_q  <= 1'b0;
    end else if (vs_fall) begin
      phase_q    <= phase_now;
      fld_vtot_q <= vcnt_q;
      fld_vact_q <= vact_q;
      fld_vld_q  <= (state_q != SEARCH);
    end
  end
`endif

  always_comb begin
    rec       = '0;
    rec.htot  = rec_htot;
    rec.hact  = (hs_fall && cap_act) ? hact_q : act_w_q;
    rec.vtot  = vcnt_q;
    rec.vact  = vact_q;
    rec.ilace = 1'b0;
`ifdef VOUT_TMEAS_INTERLACE_EN
    // both fields report the larger count so N/N+1 alternation is stable
    if (field_alt) begin
      rec.vtot  = (vcnt_q > fld_vtot_q) ? vcnt_q : fld_vtot_q;
      rec.vact  = (vact_q > fld_vact_q) ? vact_q : fld_vact_q;
      rec.ilace = 1'b1;
    end
`endif
  end

  assign rec_eq     = prev_vld_q && (rec == prev_rec_q);
  // with STABLE_FRAMES=1 a single equal comparison (two full frames) suffices
  assign stable_hit = (int'(stable_cnt_q) + 1) >= (STABLE_FRAMES - 1);
  assign pub_diff   = ({h_total_o, h_active_o, v_total_o, v_active_o, interlaced_o} != rec);

  // ---------------------------------------------------------------------------
  // Counter registers, lock FSM and published outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge VCLK_Tx or negedge nVRST_Tx) begin
    if (!nVRST_Tx) begin
      state_q          <= SEARCH;
      prev_hs_q        <= 1'b0;
      prev_vs_q        <= 1'b0;
      hcnt_q           <= '0;
      hact_q           <= '0;
      line_htot_q      <= '0;
      act_w_q          <= '0;
      vcnt_q           <= '0;
      vact_q           <= '0;
      stable_cnt_q     <= '0;
      prev_rec_q       <= '0;
      prev_vld_q       <= 1'b0;
      pub_seen_q       <= 1'b0;
      h_total_o        <= '0;
      h_active_o       <= '0;
      v_total_o        <= '0;
      v_active_o       <= '0;
      timing_valid_o   <= 1'b0;
      timing_changed_o <= 1'b0;
      interlaced_o     <= 1'b0;
    end else begin
      timing_changed_o <= 1'b0;
      if (smp) begin
        prev_hs_q <= Sync_i[1];
        prev_vs_q <= Sync_i[3];
      end
      if (line_err) begin
        // published values are kept; only the lock indication drops
        state_q        <= SEARCH;
        timing_valid_o <= 1'b0;
        stable_cnt_q   <= '0;
        prev_vld_q     <= 1'b0;
        hcnt_q         <= '0;
        hact_q         <= '0;
        line_htot_q    <= '0;
        act_w_q        <= '0;
        vcnt_q         <= '0;
        vact_q         <= '0;
      end else begin
        hcnt_q      <= hcnt_d;
        hact_q      <= hact_d;
        line_htot_q <= line_htot_d;
        act_w_q     <= act_w_d;
        vcnt_q      <= vcnt_d;
        vact_q      <= vact_d;
        if (vs_fall) begin
          case (state_q)
            SEARCH: begin
              // the frame closing here started before we were watching
              state_q      <= MEASURE;
              stable_cnt_q <= '0;
              prev_vld_q   <= 1'b0;
            end
            MEASURE: begin
              prev_rec_q <= rec;
              prev_vld_q <= 1'b1;
              if (rec_eq) begin
                if (stable_hit) begin
                  state_q          <= LOCKED;
                  h_total_o        <= rec.htot;
                  h_active_o       <= rec.hact;
                  v_total_o        <= rec.vtot;
                  v_active_o       <= rec.vact;
                  interlaced_o     <= rec.ilace;
                  timing_valid_o   <= 1'b1;
                  timing_changed_o <= pub_seen_q & pub_diff;
                  pub_seen_q       <= 1'b1;
                end else begin
                  stable_cnt_q <= stable_cnt_q + 4'd1;
                end
              end else begin
                stable_cnt_q <= '0;
              end
            end
            LOCKED: begin
              prev_rec_q <= rec;
              if (!rec_eq) begin
                state_q        <= MEASURE;
                timing_valid_o <= 1'b0;
                stable_cnt_q   <= '0;
              end
            end
            default: state_q <= SEARCH;
          endcase
        end
      end
    end
  end

endmodule
